// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled RX line, small receive FIFO, and a
// byte-wide DATA/STATUS register interface for the CPU.
module uart_rx #(
    parameter int CLKS_PER_BIT = 208,
    parameter int FIFODEPTH    = 4
) (
    input  logic       clk,
    input  logic       power_on_reset_n,
    input  logic       rx,
    input  logic       addr,
    input  logic       rd,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFODEPTH);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t          state_q;
    logic            rx_meta_q, rxs_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shift_q;
    logic [7:0]      mem_q [FIFODEPTH];
    logic [AW:0]     wptr_q, rptr_q, wptr_d, rptr_d;
    logic            frame_err_q, overrun_q, frame_err_d, overrun_d;
    logic [7:0]      dout_q;

    logic            sample, stop_ok, stop_bad;
    logic            rd_data, rd_stat, wr_stat;
    logic            empty, full, push, pop, ovr_set, busy;
    logic [1:0]      clr;

    assign sample   = (cnt_q == '0);
    assign stop_ok  = (state_q == STOP) && sample && rxs_q;
    assign stop_bad = (state_q == STOP) && sample && !rxs_q;
    assign busy     = (state_q != IDLE);

    // rd takes precedence over wr when both are strobed.
    assign rd_data = rd && !addr;
    assign rd_stat = rd && addr;
    assign wr_stat = wr && !rd && addr;
    assign clr     = wr_stat ? 2'(din >> 2) : 2'b00;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = rd_data && !empty;
    assign push    = stop_ok && (!full || pop);
    assign ovr_set = stop_ok && full && !pop;

    assign wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d      = pop  ? rptr_q + 1'b1 : rptr_q;
    assign frame_err_d = stop_bad | (frame_err_q & ~clr[0]);
    assign overrun_d   = ovr_set  | (overrun_q   & ~clr[1]);

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rxs_q) begin
                        state_q <= START;
                        cnt_q   <= HALF_BIT;
                    end
                end
                START: begin
                    if (sample) begin
                        if (rxs_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= FULL_BIT;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_q[idx_q] <= rxs_q;
                        cnt_q          <= FULL_BIT;
                        idx_q          <= idx_q + 3'd1;
                        if (idx_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                STOP: begin
                    if (sample) state_q <= rxs_q ? IDLE : WAIT_IDLE;
                    else        cnt_q   <= cnt_q - CW'(1);
                end
                WAIT_IDLE: begin
                    if (rxs_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= shift_q;
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            dout_q      <= 8'h00;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            if (rd_data)
                dout_q <= empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
            else if (rd_stat)
                dout_q <= {3'b000, busy, overrun_q, frame_err_q, full, !empty};
        end
    end

    assign dout = dout_q;
    assign irq  = !empty;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx against a queue-based model of
// the receive FIFO and status flags.
module tb_uart_rx;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, rx, addr, rd, wr;
    logic [7:0] din, dout;
    logic       irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    logic       m_ferr, m_ovr;

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFODEPTH(DEPTH)) dut (
        .clk(clk), .power_on_reset_n(rst_n), .rx(rx), .addr(addr),
        .rd(rd), .wr(wr), .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status(input logic busy);
        return {3'b000, busy, m_ovr, m_ferr, exp_q.size() == DEPTH, exp_q.size() != 0};
    endfunction

    function automatic logic [7:0] m_pop();
        if (exp_q.size() == 0) return 8'h00;
        return exp_q.pop_front();
    endfunction

    function automatic void m_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovr = 1'b1;
    endfunction

    task automatic bus_read(input logic a, output logic [7:0] d);
        addr = a;
        rd   = 1'b1;
        tick();
        rd   = 1'b0;
        d    = dout;
    endtask

    task automatic read_data(input string tag);
        logic [7:0] d, e;
        e = m_pop();
        bus_read(1'b0, d);
        check(tag, d, e);
    endtask

    task automatic read_status(input string tag, input logic busy);
        logic [7:0] d;
        bus_read(1'b1, d);
        check(tag, d, m_status(busy));
    endtask

    task automatic write_status(input logic [7:0] v);
        addr = 1'b1;
        din  = v;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
        if (v[2]) m_ferr = 1'b0;
        if (v[3]) m_ovr  = 1'b0;
    endtask

    // Drives n cycles of a frame on rx; rd is strobed in iteration rd_at.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int rd_at, input int n);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int c = 0; c < n; c++) begin
            rx   = (c < 10 * CPB) ? bits[c / CPB] : stop_bit;
            addr = 1'b0;
            rd   = (c == rd_at);
            tick();
        end
        rd = 1'b0;
    endtask

    // The stop bit is sampled in iteration 78, so a read strobed at or before
    // it pops ahead of the push, and a read at 79 pops after it.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int rd_at);
        logic [7:0] e_rd;
        e_rd = 8'h00;
        drive_frame(b, stop_bit, rd_at, 10 * CPB);
        if (rd_at >= 0 && rd_at <= 78) begin
            e_rd = m_pop();
            if (stop_bit) m_push(b);
        end else begin
            if (stop_bit) m_push(b);
            if (rd_at >= 0) e_rd = m_pop();
        end
        if (!stop_bit) m_ferr = 1'b1;
        if (rd_at >= 0) check("frame_rd", dout, e_rd);
    endtask

    initial begin
        logic [7:0] d;
        int r;
        rst_n = 1'b0; rx = 1'b1; addr = 1'b0; rd = 1'b0; wr = 1'b0; din = 8'h00;
        m_ferr = 1'b0; m_ovr = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset_dout", dout, 8'h00);
        check("reset_irq", {7'b0, irq}, 8'h00);
        read_status("reset_status", 1'b0);
        read_data("empty_read");

        // Frame 0xA5: the push shows on irq after the 79th edge from the start bit.
        drive_frame(8'hA5, 1'b1, -1, 78);
        check("irq_before_push", {7'b0, irq}, 8'h00);
        tick();
        check("irq_at_push", {7'b0, irq}, 8'h01);
        tick();
        m_push(8'hA5);
        read_status("a5_status", 1'b0);
        read_data("a5_data");
        read_status("a5_status_after", 1'b0);
        check("a5_irq_after", {7'b0, irq}, 8'h00);

        // Short low glitch is rejected at the start-bit sample.
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        read_status("glitch_busy", 1'b1);
        repeat (6) tick();
        read_status("glitch_idle", 1'b0);
        check("glitch_irq", {7'b0, irq}, 8'h00);

        // Framing error, then held in WAIT_IDLE while the line stays low.
        send(8'h3C, 1'b0, -1);
        repeat (5) tick();
        read_status("ferr_wait_idle", 1'b1);
        check("ferr_irq", {7'b0, irq}, 8'h00);
        rx = 1'b1;
        repeat (4) tick();
        read_status("ferr_idle", 1'b0);
        write_status(8'h04);
        read_status("ferr_cleared", 1'b0);

        // Overrun: five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, -1);
        read_status("ovr_status", 1'b0);
        addr = 1'b1; din = 8'h08; rd = 1'b1; wr = 1'b1;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("rd_wr_together", dout, m_status(1'b0));
        read_status("ovr_kept", 1'b0);
        addr = 1'b0; din = 8'hFF; wr = 1'b1;
        tick();
        wr = 1'b0;
        read_status("data_write_ignored", 1'b0);
        for (int i = 0; i < 5; i++) read_data("ovr_drain");
        read_status("ovr_after_drain", 1'b0);

        // Asynchronous reset in the middle of a frame.
        send(8'h11, 1'b1, -1);
        drive_frame(8'h77, 1'b1, -1, 30);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete(); m_ferr = 1'b0; m_ovr = 1'b0;
        check("midrst_dout", dout, 8'h00);
        check("midrst_irq", {7'b0, irq}, 8'h00);
        rx = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        read_status("midrst_status", 1'b0);
        send(8'h5A, 1'b1, -1);
        read_data("after_rst_5a");

        // Pop in the same cycle as a push into a full FIFO.
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, -1);
        send(8'h05, 1'b1, 78);
        read_status("push_pop_full", 1'b0);
        for (int i = 0; i < 5; i++) read_data("push_pop_drain");

        // Randomized mix of frames, reads and flag clears.
        repeat (30) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                send(8'($urandom_range(0, 255)), 1'b1,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 79)) : -1);
                repeat ($urandom_range(0, 3)) tick();
            end else if (r == 5) begin
                send(8'($urandom_range(0, 255)), 1'b0, -1);
                rx = 1'b1;
                repeat (4) tick();
            end else if (r <= 7) begin
                read_data("rand_data");
            end else if (r == 8) begin
                read_status("rand_status", 1'b0);
            end else begin
                write_status(8'($urandom_range(0, 255)));
            end
        end
        read_status("final_status", 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) read_data("final_drain");
        bus_read(1'b1, d);
        check("final_empty", d & 8'h03, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Hardware UART receiver peripheral for the f8 system: the receive end of the serial link whose transmit side the system drives by bit-banging the TX pin through GPIO. It oversamples the RX pin, decodes 8N1 frames, and buffers bytes in a small FIFO. The CPU reads the FIFO and a status register over the system's byte-wide peripheral bus, so incoming serial data no longer needs to be polled in software at bit rate.

## Interface
- CLKS_PER_BIT, 208, system clocks per bit (2 MHz / 9600 baud); legal values ≥ 4.
- FIFODEPTH, 4, receive FIFO entries; power of two, ≥ 2.

Ports:
- clk  input  1  system clock; the only clock.
- power_on_reset_n  input  1  reset, asynchronous, active-low.
- rx  input  1  serial input, idle high; asynchronous to clk.
- addr  input  1  register select: 0 = DATA, 1 = STATUS.
- rd  input  1  read strobe, one cycle.
- wr  input  1  write strobe, one cycle.
- din  input  8  write data.
- dout  output  8  registered read data.
- irq  output  1  high while the FIFO is non-empty.

## Operation
- rx passes through a 2-flop synchronizer; the synchronizer resets to 1. The FSM samples only the synchronized value rxs.
- Frame decode: the FSM states are IDLE, START, DATA, STOP, WAIT_IDLE. One down-counter, width clog2(CLKS_PER_BIT), and a 3-bit bit index.
  - IDLE: rxs = 0 → START, counter = CLKS_PER_BIT/2 − 1.
  - START: at counter 0, sample rxs. If 1, it was a glitch → IDLE, no flags. If 0 → DATA, counter = CLKS_PER_BIT − 1, index = 0.
  - DATA: at counter 0, shift rxs into bit [index], LSB first, and reload the counter. After index 7 → STOP.
  - STOP: at counter 0, sample rxs. If 1, push the byte → IDLE. If 0, set frame_err, do not push → WAIT_IDLE.
  - WAIT_IDLE: rxs = 1 → IDLE.
- FIFO push when full: drop the byte and set overrun. The FIFO contents are unchanged.
- FIFO push and pop in the same cycle: both take effect, with no overrun even when the FIFO is full. On an empty FIFO, only the push takes effect.
- DATA read (rd, addr = 0):
  - FIFO not empty: dout = head byte and the FIFO pops.
  - FIFO empty: dout = 0x00, pointers unchanged.
- STATUS read (rd, addr = 1): dout = {3'b000, busy, overrun, frame_err, full, nonempty}. busy means state ≠ IDLE.
- STATUS write (wr, addr = 1) is write-1-to-clear: din[2] clears frame_err, din[3] clears overrun. If a set and a clear land in the same cycle, the set wins.
- DATA writes are ignored. If rd and wr are asserted together, rd acts and wr is ignored.
- Reset (asynchronous, any state, including mid-frame):
  - FSM → IDLE; counter, index and shift register → 0.
  - FIFO emptied; frame_err and overrun → 0.
  - dout = 0x00, irq = 0.
  - Any partial frame is discarded. After release, a line that is still low is treated as a new start edge.

## Timing
- Let cycle t be the first cycle in which rxs = 0 while the FSM is in IDLE. rxs lags the rx pin by 2 clocks.
- Start sample at t + CLKS_PER_BIT/2.
- Data bit i (i = 0..7) is sampled at t + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample at t + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. The push is visible in nonempty and irq one cycle later.
- rd asserted in cycle n: dout valid from cycle n+1 and held until the next rd. The pop is visible in STATUS from cycle n+1.
- Back-to-back frames: the FSM returns to IDLE at mid-stop-bit. A start edge arriving at CLKS_PER_BIT/2 after that point or later is detected with no lost frame.
- Baud tolerance: about ±4% of total mismatch between transmitter and receiver is tolerated by design.

## Test plan
All scenarios use CLKS_PER_BIT = 8 and FIFODEPTH = 4.
- Reset then idle line: dout = 0x00, irq = 0, STATUS = 0x00. A DATA read on the empty FIFO returns 0x00.
- Send frame 0xA5 (8N1): irq rises exactly t+77+1 after the start edge. STATUS = 0x01. A DATA read returns 0xA5, after which STATUS = 0x00 and irq = 0.
- Drive a 3-cycle low glitch on rx: no push, no flags, busy returns to 0 within 6 cycles.
- Send frame 0x3C with the stop bit held low: no push, STATUS = 0x04 (frame_err); the FSM stays in WAIT_IDLE until rx goes high. Writing 0x04 to STATUS gives STATUS = 0x00.
- Send 5 bytes 0x01..0x05 without reading: STATUS = 0x0B (overrun, full, nonempty). Reads return 0x01..0x04, then 0x00. Pulse power_on_reset_n low mid-frame: all state cleared, and the following frame 0x5A is received correctly.
- Fill the FIFO and issue a DATA read in the exact cycle the 5th stop bit is pushed: no overrun, and subsequent reads return bytes 2..5.
